// File: rtl/dense_layer_axil_master.sv
// Single-outstanding AXI4-Lite initiator: turns a command/response handshake into AXI-Lite
// write and read transactions. Optional watchdog enabled by DENSE_AXIL_MST_TIMEOUT_EN.
module dense_layer_axil_master #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [ADDR_WIDTH-1:0] m_awaddr,
   output logic                  m_awvalid,
   input  logic                  m_awready,
   output logic [31:0]           m_wdata,
   output logic [3:0]            m_wstrb,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [1:0]            m_bresp,
   input  logic                  m_bvalid,
   output logic                  m_bready,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [31:0]           m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   output logic                  timeout_err
);

   typedef enum logic [2:0] {StIdle, StWr, StWb, StRa, StRd, StRsp} state_e;

   state_e                state_q, state_d;
   logic                  up_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [3:0]            wstrb_q;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  accept;

   // up_q keeps cmd_ready low while reset is asserted even though the FSM sits in idle
   assign cmd_ready = up_q && (state_q == StIdle);
   assign accept    = cmd_valid && cmd_ready;

   assign m_awvalid = (state_q == StWr) && !aw_done_q;
   assign m_wvalid  = (state_q == StWr) && !w_done_q;
   assign m_bready  = (state_q == StWb);
   assign m_arvalid = (state_q == StRa);
   assign m_rready  = (state_q == StRd);
   assign rsp_valid = (state_q == StRsp);
   assign m_awaddr  = addr_q;
   assign m_araddr  = addr_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign rsp_rdata = rdata_q;
   assign rsp_resp  = resp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         up_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= '0;
      end else begin
         state_q   <= state_d;
         up_q      <= 1'b1;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_write ? StWr : StRa;
            end
         end
         StWr: begin
            // AW and W complete independently, in either order or together
            if (m_awvalid && m_awready) aw_done_d = 1'b1;
            if (m_wvalid && m_wready)   w_done_d  = 1'b1;
            if (aw_done_d && w_done_d)  state_d   = StWb;
         end
         StWb: begin
            if (m_bvalid) begin
               resp_d  = m_bresp;
               rdata_d = '0;
               state_d = StRsp;
            end
         end
         StRa: begin
            if (m_arready) state_d = StRd;
         end
         StRd: begin
            if (m_rvalid) begin
               rdata_d = m_rdata;
               resp_d  = m_rresp;
               state_d = StRsp;
            end
         end
         StRsp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef DENSE_AXIL_MST_TIMEOUT_EN
   logic [31:0] cnt_q;
   logic        err_q;
   logic        busy;

   assign busy = (state_q == StWr) || (state_q == StWb) || (state_q == StRa) ||
                 (state_q == StRd);
   assign timeout_err = err_q;

   // The flag only reports; the transaction keeps waiting so the bus stays legal
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (!busy)              cnt_q <= '0;
         else if (cnt_q != '1)   cnt_q <= cnt_q + 32'd1;
         if (accept)             err_q <= 1'b0;
         else if (busy && (cnt_q == 32'(TIMEOUT_CYC - 1))) err_q <= 1'b1;
      end
   end
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dense_layer_axil_master.sv
// Randomized bench for dense_layer_axil_master: AXI-Lite slave with programmable stalls plus
// a word-array reference model of the register space and response-code rule.
`timescale 1ns/1ps
module tb_dense_layer_axil_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [3:0]  m_wstrb;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready, timeout_err;
   logic [1:0]  m_bresp, m_rresp;

   always #5 clk = ~clk;

   dense_layer_axil_master #(.ADDR_WIDTH(32), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .timeout_err(timeout_err)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Address bit 9 selects DECERR, bit 8 SLVERR; word index is addr[7:2]
   function automatic logic [1:0] resp_rule(input logic [31:0] a);
      if (a[9]) return 2'b11;
      if (a[8]) return 2'b10;
      return 2'b00;
   endfunction

   // ---------------- slave ----------------
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   int aw_wait, w_wait, b_wait, ar_wait, r_wait;
   logic aw_got, w_got, b_pend, r_pend;
   logic [31:0] aw_a, w_d, r_data;
   logic [3:0]  w_s;
   logic [1:0]  b_resp, r_resp;
   logic [7:0]  s_mem [0:255];
   int nb_hs = 0;
   logic aw_hs, w_hs, ar_hs;
   logic [31:0] wr_a, wr_d;
   logic [3:0]  wr_s;

   assign m_awready = m_awvalid && (aw_wait >= aw_dly);
   assign m_wready  = m_wvalid && (w_wait >= w_dly);
   assign m_arready = m_arvalid && (ar_wait >= ar_dly);
   assign m_bvalid  = b_pend && (b_wait >= b_dly);
   assign m_rvalid  = r_pend && (r_wait >= r_dly);
   assign m_bresp   = b_resp;
   assign m_rdata   = r_data;
   assign m_rresp   = r_resp;
   assign aw_hs = m_awvalid && m_awready;
   assign w_hs  = m_wvalid && m_wready;
   assign ar_hs = m_arvalid && m_arready;
   assign wr_a  = aw_hs ? m_awaddr : aw_a;
   assign wr_d  = w_hs ? m_wdata : w_d;
   assign wr_s  = w_hs ? m_wstrb : w_s;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
         aw_a <= '0; w_d <= '0; w_s <= '0; b_resp <= '0; r_resp <= '0; r_data <= '0;
         for (int i = 0; i < 256; i++) s_mem[i] <= 8'h00;
      end else begin
         if (aw_hs) begin aw_got <= 1'b1; aw_a <= m_awaddr; aw_wait <= 0; end
         else if (m_awvalid) aw_wait <= aw_wait + 1;
         if (w_hs) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; w_wait <= 0; end
         else if (m_wvalid) w_wait <= w_wait + 1;
         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            for (int i = 0; i < 4; i++)
               if (wr_s[i]) s_mem[{wr_a[7:2], 2'(i)}] <= wr_d[8*i +: 8];
            b_pend <= 1'b1; b_resp <= resp_rule(wr_a); b_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
         end
         if (m_bvalid && m_bready) begin b_pend <= 1'b0; nb_hs <= nb_hs + 1; end
         else if (b_pend) b_wait <= b_wait + 1;
         if (ar_hs) begin
            r_pend <= 1'b1; r_wait <= 0; ar_wait <= 0; r_resp <= resp_rule(m_araddr);
            r_data <= {s_mem[{m_araddr[7:2], 2'd3}], s_mem[{m_araddr[7:2], 2'd2}],
                       s_mem[{m_araddr[7:2], 2'd1}], s_mem[{m_araddr[7:2], 2'd0}]};
         end else if (m_arvalid) ar_wait <= ar_wait + 1;
         if (m_rvalid && m_rready) r_pend <= 1'b0;
         else if (r_pend) r_wait <= r_wait + 1;
      end
   end

   // ---------------- stability / activity monitor ----------------
   logic pa, pw, par, prsp;
   logic [31:0] sa, sw, sar;
   logic [3:0]  ss;
   logic [33:0] srsp;
   int stab_err = 0, aw_cyc = 0, w_cyc = 0, ar_cyc = 0;

   always @(posedge clk) begin
      pa   <= m_awvalid && !m_awready && !rst;  sa  <= m_awaddr;
      pw   <= m_wvalid && !m_wready && !rst;    sw  <= m_wdata;  ss <= m_wstrb;
      par  <= m_arvalid && !m_arready && !rst;  sar <= m_araddr;
      prsp <= rsp_valid && !rsp_ready && !rst;  srsp <= {rsp_resp, rsp_rdata};
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (pa && (!m_awvalid || m_awaddr != sa)) stab_err++;
         if (pw && (!m_wvalid || m_wdata != sw || m_wstrb != ss)) stab_err++;
         if (par && (!m_arvalid || m_araddr != sar)) stab_err++;
         if (prsp && (!rsp_valid || {rsp_resp, rsp_rdata} != srsp)) stab_err++;
         if (m_awvalid) aw_cyc++;
         if (m_wvalid) w_cyc++;
         if (m_arvalid) ar_cyc++;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] exp_mem [0:63];

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int i = 0; i < 4; i++)
         if (s[i]) exp_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) exp_mem[i] = '0;
   endtask

   // Issue one command from a negedge; lat = cycles from accept to first rsp_valid
   task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int rdly, output logic [31:0] rd,
                          output logic [1:0] rr, output int lat);
      int n;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      n = 0;
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0; rd = '0; rr = '0; lat = -1;
         return;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
      repeat (rdly) @(negedge clk);
      rd = rsp_rdata; rr = rsp_resp;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
      aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, a, d;
      logic [1:0]  rr;
      logic [3:0]  s;
      logic        wr;
      int lat, c0, c1, c2, m, rdly;

      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_wstrb = '0; rsp_ready = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      check("reset_ctrl", {24'd0, cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid,
                           m_rready, rsp_valid, timeout_err}, 32'd0);
      check("reset_rdata", rsp_rdata, 32'd0);
      check("reset_resp", 32'(rsp_resp), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(cmd_ready), 32'd1);

      // Zero-wait write, cycle-exact
      set_dly(0, 0, 0, 0, 0);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
      model_write(32'h0, 32'h1, 4'hF);
      check("wr_t1_aw_w", {30'd0, m_awvalid, m_wvalid}, 32'd3);
      check("wr_t1_ready_low", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check("wr_t2_bready", {29'd0, m_bready, m_awvalid, m_wvalid}, 32'd4);
      check("wr_t2_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("wr_t3_rsp", {29'd0, rsp_valid, rsp_resp}, 32'd4);
      check("wr_t3_rdata", rsp_rdata, 32'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("wr_ready_again", 32'(cmd_ready), 32'd1);

      // Read with 5-cycle arready stall
      run_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, rr, lat);
      model_write(32'h10, 32'hDEADBEEF, 4'hF);
      set_dly(0, 0, 0, 5, 0);
      c0 = ar_cyc;
      run_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, rr, lat);
      check("stall_rdata", rd, exp_mem[4]);
      check("stall_ar_cycles", 32'(ar_cyc - c0), 32'd6);
      check("stall_latency", 32'(lat), 32'd8);

      // W accepted 3 cycles before AW
      set_dly(3, 0, 0, 0, 0);
      c0 = aw_cyc; c1 = w_cyc; c2 = nb_hs;
      run_cmd(1'b1, 32'h14, 32'h12345678, 4'b0101, 1, rd, rr, lat);
      model_write(32'h14, 32'h12345678, 4'b0101);
      check("wfirst_w_cycles", 32'(w_cyc - c1), 32'd1);
      check("wfirst_aw_cycles", 32'(aw_cyc - c0), 32'd4);
      check("wfirst_one_b", 32'(nb_hs - c2), 32'd1);
      check("wfirst_latency", 32'(lat), 32'd6);
      set_dly(0, 0, 0, 0, 0);
      run_cmd(1'b0, 32'h14, 32'h0, 4'h0, 0, rd, rr, lat);
      check("wfirst_readback", rd, exp_mem[5]);

      // Error response passes through; next command behaves normally
      run_cmd(1'b0, 32'h118, 32'h0, 4'h0, 0, rd, rr, lat);
      check("slverr_resp", 32'(rr), 32'd2);
      run_cmd(1'b1, 32'h18, 32'hA5A5A5A5, 4'hF, 0, rd, rr, lat);
      model_write(32'h18, 32'hA5A5A5A5, 4'hF);
      check("after_err_resp", 32'(rr), 32'd0);
      check("after_err_latency", 32'(lat), 32'd3);

      // Reset while waiting in WB with B pending
      set_dly(0, 0, 50, 0, 0);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("wb_bready", 32'(m_bready), 32'd1);
      rst = 1'b1;
      #1;
      check("midreset_ctrl", {24'd0, cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid,
                              m_rready, rsp_valid, timeout_err}, 32'd0);
      check("midreset_rsp", {rsp_resp, rsp_rdata[29:0]}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      set_dly(0, 0, 0, 0, 0);
      run_cmd(1'b1, 32'h24, 32'hCAFEF00D, 4'hF, 0, rd, rr, lat);
      model_write(32'h24, 32'hCAFEF00D, 4'hF);
      run_cmd(1'b0, 32'h24, 32'h0, 4'h0, 0, rd, rr, lat);
      check("postreset_rdata", rd, exp_mem[9]);
      check("postreset_latency", 32'(lat), 32'd3);

`ifdef DENSE_AXIL_MST_TIMEOUT_EN
      // Slave withholds arready: flag after 16 busy cycles, arvalid still held
      set_dly(0, 0, 0, 100000, 0);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24; cmd_wstrb = 4'h0;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (15) @(negedge clk);
      check("timeout_not_yet", 32'(timeout_err), 32'd0);
      @(negedge clk);
      check("timeout_set", {30'd0, timeout_err, m_arvalid}, 32'd3);
      ar_dly = 0;
      m = 0;
      while (!rsp_valid && m < 50) begin @(negedge clk); m++; end
      check("timeout_rdata", rsp_rdata, exp_mem[9]);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("timeout_sticky", 32'(timeout_err), 32'd1);
      run_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, rr, lat);
      check("timeout_cleared", 32'(timeout_err), 32'd0);
`endif

      // Randomized traffic against the word-array model
      for (int it = 0; it < 40; it++) begin
         wr = 1'($urandom_range(0, 1));
         m = $urandom_range(0, 7);
         a = {22'd0, (m == 0) ? 2'b10 : (m == 1) ? 2'b01 : 2'b00,
              6'($urandom_range(0, 63)), 2'b00};
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
         rdly = $urandom_range(0, 2);
         run_cmd(wr, a, d, s, rdly, rd, rr, lat);
         check("rnd_resp", 32'(rr), 32'(resp_rule(a)));
         if (wr) begin
            model_write(a, d, s);
            check("rnd_wr_rdata", rd, 32'd0);
            check("rnd_wr_latency", 32'(lat),
                  32'(3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly));
         end else begin
            check("rnd_rd_rdata", rd, exp_mem[a[7:2]]);
            check("rnd_rd_latency", 32'(lat), 32'(3 + ar_dly + r_dly));
         end
      end

      check("valid_payload_stable", 32'(stab_err), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
